// File: rtl/tail_ring_buffer_if.sv
// rtl/tail_ring_buffer_if.sv - enqueue/dequeue/read-port bundle for tail_ring_buffer
interface tail_ring_buffer_if #(
    parameter int DEPTH = 21,
    parameter int WIDTH = 6,
    parameter int NREAD = 2
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic                   flush;
    logic                   enq_valid;
    logic                   enq_ready;
    logic [WIDTH-1:0]       enq_data;
    logic                   deq_valid;
    logic                   deq_ready;
    logic [WIDTH-1:0]       deq_data;
    logic [NREAD-1:0]       rd_en;
    logic [NREAD*IW-1:0]    rd_off;
    logic [NREAD-1:0]       rd_valid;
    logic [NREAD*WIDTH-1:0] rd_data;
    logic [CW-1:0]          count;

    // allocator / retire / lookup side
    modport master (
        output flush, enq_valid, enq_data, deq_ready, rd_en, rd_off,
        input  enq_ready, deq_valid, deq_data, rd_valid, rd_data, count
    );

    // buffer side
    modport slave (
        input  flush, enq_valid, enq_data, deq_ready, rd_en, rd_off,
        output enq_ready, deq_valid, deq_data, rd_valid, rd_data, count
    );
endinterface

// File: rtl/tail_ring_buffer.sv
// rtl/tail_ring_buffer.sv - in-order circular buffer with head-relative registered read ports
module tail_ring_buffer #(
    parameter int DEPTH = 21,
    parameter int WIDTH = 6,
    parameter int NREAD = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    tail_ring_buffer_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [IW-1:0] LAST    = IW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [IW:0]   DEPTH_W = (IW + 1)'(DEPTH);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [IW-1:0]          head;
    logic [IW-1:0]          tail;
    logic [CW-1:0]          cnt;
    logic [NREAD-1:0]       rd_valid_q;
    logic [NREAD*WIDTH-1:0] rd_data_q;

    logic not_full;
    logic not_empty;
    logic enq_fire;
    logic deq_fire;

    logic [IW-1:0]    rd_off_a [NREAD];
    logic [IW:0]      rd_sum   [NREAD];
    logic [IW-1:0]    rd_idx   [NREAD];
    logic [NREAD-1:0] rd_live;
    logic [NREAD-1:0] rd_oob;
    logic [WIDTH-1:0] rd_word  [NREAD];

    // Status comes only from registered state; no pass-through when full.
    assign not_full  = (cnt != FULL);
    assign not_empty = (cnt != '0);
    assign enq_fire  = bus.enq_valid & not_full & ~bus.flush;
    assign deq_fire  = bus.deq_ready & not_empty & ~bus.flush;

    assign bus.enq_ready = not_full;
    assign bus.deq_valid = not_empty;
    assign bus.deq_data  = mem[head];
    assign bus.count     = cnt;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;

    // Head-relative address resolution with explicit wrap and same-cycle enqueue bypass.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd_off_a[i] = bus.rd_off[i*IW +: IW];
            rd_sum[i]   = {1'b0, head} + {1'b0, rd_off_a[i]};
            rd_idx[i]   = (rd_sum[i] >= DEPTH_W) ? IW'(rd_sum[i] - DEPTH_W) : rd_sum[i][IW-1:0];
            rd_live[i]  = (CW'(rd_off_a[i]) < cnt);
            rd_oob[i]   = ({1'b0, rd_off_a[i]} >= DEPTH_W);
            if (rd_oob[i]) begin
                rd_word[i] = '0;
            end else if (enq_fire && (tail == rd_idx[i])) begin
                rd_word[i] = bus.enq_data;
            end else begin
                rd_word[i] = mem[rd_idx[i]];
            end
        end
    end

    // Storage is deliberately not reset; contents are only meaningful while live.
    always_ff @(posedge clock) begin
        if (enq_fire) begin
            mem[tail] <= bus.enq_data;
        end
    end

    // Pointer and occupancy update; flush discards this cycle's handshakes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (bus.flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (enq_fire) begin
                tail <= (tail == LAST) ? '0 : tail + 1'b1;
            end
            if (deq_fire) begin
                head <= (head == LAST) ? '0 : head + 1'b1;
            end
            case ({enq_fire, deq_fire})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Read ports: one-cycle latency; data holds when a port is idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            for (int i = 0; i < NREAD; i++) begin
                rd_valid_q[i] <= bus.rd_en[i] & rd_live[i] & ~bus.flush;
                if (bus.rd_en[i]) begin
                    rd_data_q[i*WIDTH +: WIDTH] <= rd_word[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_tail_ring_buffer.sv
// tb/tb_tail_ring_buffer.sv - directed self-checking bench for tail_ring_buffer
module tb_tail_ring_buffer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    tail_ring_buffer_if #(.DEPTH(21), .WIDTH(6), .NREAD(2)) bus ();

    tail_ring_buffer #(.DEPTH(21), .WIDTH(6), .NREAD(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic enq(input logic [5:0] d);
        bus.enq_valid = 1'b1;
        bus.enq_data  = d;
        step();
        bus.enq_valid = 1'b0;
    endtask

    task automatic deq_chk(input logic [5:0] exp);
        check("deq_data", bus.deq_data, exp);
        bus.deq_ready = 1'b1;
        step();
        bus.deq_ready = 1'b0;
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.enq_valid = 1'b0;
        bus.enq_data  = '0;
        bus.deq_ready = 1'b0;
        bus.rd_en     = '0;
        bus.rd_off    = '0;
        step();
        step();
        reset_n = 1'b1;
        step();

        // reset state
        check("rst_count", bus.count, 0);
        check("rst_enq_ready", bus.enq_ready, 1);
        check("rst_deq_valid", bus.deq_valid, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);

        // fill 0..20
        for (int i = 0; i < 21; i++) enq(6'(i));
        check("full_count", bus.count, 21);
        check("full_enq_ready", bus.enq_ready, 0);
        check("full_deq_valid", bus.deq_valid, 1);
        check("full_deq_data", bus.deq_data, 0);

        // 22nd enqueue blocked even though deq fires
        bus.enq_valid = 1'b1;
        bus.enq_data  = 6'h3F;
        bus.deq_ready = 1'b1;
        step();
        bus.enq_valid = 1'b0;
        bus.deq_ready = 1'b0;
        check("full_deq_count", bus.count, 20);
        check("full_deq_head", bus.deq_data, 1);

        // slot 0 must still hold its original value (offset 20 from head 1)
        bus.rd_en  = 2'b01;
        bus.rd_off = {5'd0, 5'd20};
        step();
        bus.rd_en = 2'b00;
        check("blocked_rd_valid", bus.rd_valid, 0);
        check("blocked_rd_data", bus.rd_data[5:0], 0);

        // wrap: dequeue to head 5, enqueue 0x2A..0x2E into slots 0..4
        for (int i = 1; i < 5; i++) deq_chk(6'(i));
        for (int i = 0; i < 5; i++) enq(6'(8'h2A + i));
        check("wrap_count", bus.count, 21);
        check("wrap_enq_ready", bus.enq_ready, 0);
        for (int i = 5; i < 21; i++) deq_chk(6'(i));
        for (int i = 0; i < 5; i++) deq_chk(6'(8'h2A + i));
        check("drain_count", bus.count, 0);
        check("drain_deq_valid", bus.deq_valid, 0);

        // move head/tail to 16 via slots 5..15 = 0x10..0x1A
        for (int j = 0; j < 11; j++) enq(6'(8'h10 + j));
        for (int j = 0; j < 11; j++) deq_chk(6'(8'h10 + j));
        // slots 16..20,0..4 = 0x30..0x39
        for (int k = 0; k < 10; k++) enq(6'(8'h30 + k));
        check("h16_count", bus.count, 10);

        // offset 7 -> slot 2 (0x37); offset 10 -> slot 5 (0x10), not live
        bus.rd_en  = 2'b11;
        bus.rd_off = {5'd10, 5'd7};
        step();
        check("wrap_rd_valid", bus.rd_valid, 2'b01);
        check("wrap_rd0_data", bus.rd_data[5:0], 6'h37);
        check("wrap_rd1_data", bus.rd_data[11:6], 6'h10);

        // flush with reads pending
        bus.rd_off = '0;
        bus.flush  = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.rd_en = 2'b00;
        check("flush_count", bus.count, 0);
        check("flush_deq_valid", bus.deq_valid, 0);
        check("flush_rd_valid", bus.rd_valid, 0);

        // bypass at tail 3, count 3
        enq(6'h01);
        enq(6'h02);
        enq(6'h03);
        bus.enq_valid = 1'b1;
        bus.enq_data  = 6'h15;
        bus.rd_en     = 2'b10;
        bus.rd_off    = {5'd3, 5'd0};
        step();
        bus.enq_valid = 1'b0;
        check("byp_rd_valid", bus.rd_valid, 2'b00);
        check("byp_rd1_data", bus.rd_data[11:6], 6'h15);
        step();
        bus.rd_en = 2'b00;
        check("byp_rep_valid", bus.rd_valid, 2'b10);
        check("byp_rep_data", bus.rd_data[11:6], 6'h15);

        // count 7, then simultaneous enq+deq
        enq(6'h04);
        enq(6'h05);
        enq(6'h06);
        check("c7_count", bus.count, 7);
        bus.enq_valid = 1'b1;
        bus.enq_data  = 6'h07;
        bus.deq_ready = 1'b1;
        step();
        bus.enq_valid = 1'b0;
        bus.deq_ready = 1'b0;
        check("both_count", bus.count, 7);
        check("both_head", bus.deq_data, 6'h02);
        bus.rd_en  = 2'b01;
        bus.rd_off = {5'd0, 5'd6};
        step();
        bus.rd_en = 2'b00;
        check("both_tail_valid", bus.rd_valid, 2'b01);
        check("both_tail_data", bus.rd_data[5:0], 6'h07);

        // flush with enq: slot 8 must keep 0x13
        bus.enq_valid = 1'b1;
        bus.enq_data  = 6'h3C;
        bus.deq_ready = 1'b1;
        bus.flush     = 1'b1;
        step();
        bus.enq_valid = 1'b0;
        bus.deq_ready = 1'b0;
        bus.flush     = 1'b0;
        check("fenq_count", bus.count, 0);
        check("fenq_deq_valid", bus.deq_valid, 0);
        check("fenq_enq_ready", bus.enq_ready, 1);
        bus.rd_en  = 2'b01;
        bus.rd_off = {5'd0, 5'd8};
        step();
        bus.rd_en = 2'b00;
        check("fenq_rd_valid", bus.rd_valid, 0);
        check("fenq_slot8", bus.rd_data[5:0], 6'h13);

        // async reset mid-stream at count 12 with both ports valid
        for (int i = 0; i < 12; i++) enq(6'(8'h20 + i));
        bus.rd_en  = 2'b11;
        bus.rd_off = {5'd1, 5'd0};
        step();
        check("pre_rst_rd_valid", bus.rd_valid, 2'b11);
        check("pre_rst_count", bus.count, 12);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_count", bus.count, 0);
        check("arst_enq_ready", bus.enq_ready, 1);
        check("arst_deq_valid", bus.deq_valid, 0);
        check("arst_rd_valid", bus.rd_valid, 0);
        check("arst_rd_data", bus.rd_data, 0);
        bus.rd_en = 2'b00;
        step();
        step();
        reset_n = 1'b1;
        enq(6'h2D);
        check("post_rst_count", bus.count, 1);
        check("post_rst_deq_valid", bus.deq_valid, 1);
        check("post_rst_slot0", bus.deq_data, 6'h2D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tail_ring_buffer.md
# tail_ring_buffer

Parametrised circular buffer for tracking in-flight entries in order. It generalises the fixed 21x6 tail storage array to any depth and width, and adds a head/tail pointer pair, occupancy tracking, and NREAD registered random-access read ports addressed relative to head. It sits between an allocator that enqueues at the tail and a retire stage that dequeues at the head. Lookup logic reads arbitrary live entries through the read ports.

## Interface
- DEPTH, 21: number of entries; any value ≥2, power of two not required.
- WIDTH, 6: bits per entry.
- NREAD, 2: number of random-access read ports.
- IW, derived: $clog2(DEPTH); width of offsets.
- CW, derived: $clog2(DEPTH+1); width of count.

Ports:
- clock, in, 1: sole clock; all state updates on posedge.
- reset_n, in, 1: asynchronous, active-low reset.
- flush, in, 1: synchronous empty; takes priority over enq and deq.
- enq_valid, in, 1: enqueue request.
- enq_ready, out, 1: equals count != DEPTH.
- enq_data, in, WIDTH: data written at tail.
- deq_valid, out, 1: equals count != 0.
- deq_ready, in, 1: dequeue request.
- deq_data, out, WIDTH: mem[head], combinational (first-word fall-through). Undefined when deq_valid=0.
- rd_en, in, NREAD: per-port read request.
- rd_off, in, NREAD*IW: per-port offset from head; port i uses bits [i*IW +: IW].
- rd_valid, out, NREAD: registered; the request hit a live entry.
- rd_data, out, NREAD*WIDTH: registered read data.
- count, out, CW: current occupancy.

## Operation
- State: head and tail, each IW bits in 0..DEPTH-1. count, CW bits. Storage array mem[DEPTH][WIDTH], not reset. rd_valid and rd_data registers.
- Handshakes:
  - enq fires when enq_valid & enq_ready. It writes mem[tail] <= enq_data, and tail advances.
  - deq fires when deq_valid & deq_ready, and head advances.
- Pointer advance: if ptr == DEPTH-1 the next value is 0, otherwise ptr+1. Never rely on modulo-2^IW wrap.
- Count update:
  - enq only: +1.
  - deq only: -1.
  - both, or neither: unchanged.
- Full: no enqueue when count==DEPTH, even if deq fires in the same cycle. There is no pass-through when full.
- Empty: deq_ready is ignored when count==0. An enqueue into an empty buffer is visible on deq_data/deq_valid the next cycle.
- flush, when high at a clock edge:
  - head, tail and count go to 0.
  - enq and deq handshakes that cycle are discarded and mem is not written.
  - rd_valid goes to 0 the next cycle.
- Read port i, sampled at the edge where rd_en[i]=1:
  - Physical index p = head + rd_off[i], minus DEPTH if the sum ≥ DEPTH. The sum is computed IW+1 bits wide.
  - rd_valid[i] <= (rd_off[i] < count) & ~flush.
  - rd_data[i] <= mem[p], with write-first bypass: if an enqueue fires the same cycle with tail == p, capture enq_data instead.
  - rd_off ≥ count gives rd_valid=0. rd_data still loads mem[p], or 0 if rd_off ≥ DEPTH.
- If rd_en[i]=0: rd_valid[i] <= 0 and rd_data[i] holds its previous value.
- Head, count and tail are sampled before this cycle's updates. A deq in the same cycle does not shift the offset base.

## Timing
- Reset, asynchronous on reset_n low, released synchronously by the integrator:
  - head=0, tail=0, count=0.
  - rd_valid=0, rd_data=0.
  - Therefore enq_ready=1 and deq_valid=0.
- deq_data, deq_valid, enq_ready and count are functions of registered state only, with no input-to-output combinational path.
- Read ports: 1-cycle latency, fully pipelined, one request per port per cycle. Ports are independent, and any number may target the same entry.
- Enqueue-to-read: an entry written at edge N can be requested at edge N (via bypass) or later.
- Reset asserted mid-operation immediately zeroes all pointers and outputs listed above. Storage contents after reset are don't-care.

## Test plan
- Reset and fill, DEPTH=21, WIDTH=6:
  - After reset: count=0, enq_ready=1, deq_valid=0, rd_valid=0.
  - Enqueue 0..20 back-to-back: count=21 and enq_ready=0.
  - A 22nd enq_valid is ignored, even with deq_ready=1 in the same cycle.
- Wrap-around:
  - Enqueue 21 entries, dequeue 5, enqueue 0x2A..0x2E. Tail wraps 20→0 and ends at 5.
  - Dequeue order returns the remaining originals, then 0x2A..0x2E.
- Read offsets across wrap:
  - With head=16 and count=10, rd_off=7 reads physical slot 2 and returns that slot's data with rd_valid=1 one cycle later.
  - rd_off=10 gives rd_valid=0.
- Bypass:
  - With count=3 and tail=3, enqueue 0x15 while port 1 requests rd_off=3. Next cycle rd_data[1]=0x15.
  - rd_valid[1]=0, because offset 3 is not < count=3 at sampling.
  - A repeat next cycle gives rd_valid=1, data 0x15.
- Simultaneous enq+deq, and flush:
  - At count=7, fire both handshakes: count stays 7 and head and tail both advance.
  - Then assert flush together with enq: count=0, deq_valid=0, and the enqueued data never appears.
- Async reset mid-stream:
  - Drop reset_n between edges while count=12 and rd_valid=2'b11. Outputs go to their reset values without waiting for a clock edge.
  - Resume after release: the first enqueue lands at slot 0.
